fir_coeff_ctrl: RTL

Controller placed in front of the pipelined transposed-form FIR datapath.
- Accepts a streamed coefficient set into a shadow bank over a valid/ready config port.
- Swaps the shadow bank into the active bank only after the FIR pipeline has drained, so old and new coefficients never mix in partial sums.
- Gates the input sample stream into the FIR and produces an output-valid strobe aligned to the FIR latency.

---
 rtl/fir_coeff_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fir_coeff_ctrl.sv
// Coefficient bank controller for the transposed-form FIR: shadow loading, drained bank swap, sample gating.
// Optional macro SYM_COEF_EN: load a symmetric set of (N_TAPS+1)/2 words that is mirrored into the shadow bank.
module fir_coeff_ctrl #(
  parameter int N_TAPS  = 33,
  parameter int COEF_W  = 24,
  parameter int DATA_W  = 24,
  parameter int FIR_LAT = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [COEF_W-1:0]          cfg_data,
  input  logic                       cfg_last,
  output logic                       cfg_err,
  input  logic                       cfg_err_clr,
  input  logic                       swap_req,
  output logic                       swap_ack,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  output logic [DATA_W-1:0]          fir_din,
  output logic [N_TAPS*COEF_W-1:0]   coeff_flat,
  output logic                       out_valid
);

`ifdef SYM_COEF_EN
  localparam int SET_LEN = (N_TAPS + 1) / 2;
`else
  localparam int SET_LEN = N_TAPS;
`endif
  localparam int IDX_W     = $clog2(N_TAPS);
  localparam int DRAIN_CYC = N_TAPS + FIR_LAT;
  localparam int CNT_W     = $clog2(DRAIN_CYC + 1);
  localparam int FLAT_W    = N_TAPS * COEF_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SET_LEN - 1);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 shadow_full_q, shadow_full_d;
  logic [FLAT_W-1:0]    shadow_q, shadow_d;
  logic [FLAT_W-1:0]    active_q, active_d;
  logic [FIR_LAT-1:0]   pipe_q, pipe_d;
  logic [DATA_W-1:0]    fir_din_q, fir_din_d;
  logic                 out_valid_q, out_valid_d;
  logic                 swap_ack_q, swap_ack_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 cfg_ready_q, cfg_ready_d;
  logic                 s_ready_q, s_ready_d;
  logic                 s_accept, cfg_accept, err_set;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shadow_full_d = shadow_full_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    swap_ack_d    = 1'b0;
    err_set       = 1'b0;

    s_accept   = s_valid && s_ready_q;
    cfg_accept = cfg_valid && cfg_ready_q;

    // s_ready is low throughout DRAIN, so this also forces zero bubbles there
    fir_din_d = s_accept ? s_data : '0;
    pipe_d[0] = s_accept;
    for (int i = 1; i < FIR_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    out_valid_d = pipe_q[FIR_LAT-1];

    case (state_q)
      RUN: begin
        if (swap_req && shadow_full_q) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        // Swap lands with the ack in the last gated cycle; samples resume one cycle later
        if (cnt_q == CNT_W'(DRAIN_CYC - 2)) begin
          active_d      = shadow_q;
          shadow_full_d = 1'b0;
          idx_d         = '0;
          swap_ack_d    = 1'b1;
        end
        if (cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: state_d = RUN;
    endcase

    // Config words only arrive in RUN with an empty shadow, so never collide with the swap
    if (cfg_accept) begin
      shadow_d[int'(idx_q)*COEF_W +: COEF_W] = cfg_data;
`ifdef SYM_COEF_EN
      shadow_d[(N_TAPS-1-int'(idx_q))*COEF_W +: COEF_W] = cfg_data;
`endif
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
        if (cfg_last) shadow_full_d = 1'b1;
        else          err_set       = 1'b1;
      end else if (cfg_last) begin
        idx_d   = '0;
        err_set = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    cfg_err_d   = err_set | (cfg_err_q & ~cfg_err_clr);
    cfg_ready_d = !shadow_full_d && (state_d == RUN);
    s_ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_full_q <= 1'b0;
      shadow_q      <= '0;
      active_q      <= '0;
      pipe_q        <= '0;
      fir_din_q     <= '0;
      out_valid_q   <= 1'b0;
      swap_ack_q    <= 1'b0;
      cfg_err_q     <= 1'b0;
      cfg_ready_q   <= 1'b1;
      s_ready_q     <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_full_q <= shadow_full_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pipe_q        <= pipe_d;
      fir_din_q     <= fir_din_d;
      out_valid_q   <= out_valid_d;
      swap_ack_q    <= swap_ack_d;
      cfg_err_q     <= cfg_err_d;
      cfg_ready_q   <= cfg_ready_d;
      s_ready_q     <= s_ready_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign cfg_err    = cfg_err_q;
  assign swap_ack   = swap_ack_q;
  assign s_ready    = s_ready_q;
  assign fir_din    = fir_din_q;
  assign coeff_flat = active_q;
  assign out_valid  = out_valid_q;

endmodule
